// File: rtl/opb_register_bank.sv
// -----------------------------------------------------------------------------
// opb_register_bank
//
// OPB slave that exposes C_NUM_REGS 32-bit software registers in one
// contiguous address window (register k at C_BASEADDR + 4k). It supports
// byte-enable writes, a one-cycle write strobe per register, self-clearing
// pulse bits (C_PULSE_MASK) and read-only status registers (C_RO_MASK). Those
// registers read back the matching slice of user_status_in.
//
// Optional build macro: REG_BANK_SHADOW_EN
//   When defined, writes land in a shadow set and are copied to user_data_out
//   when user_commit is high. Reads return the shadow contents.
//
// Ports:
//   OPB_Clk, OPB_Rst_n     clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW   OPB request (big-endian bit numbering, bit 0 = MSB)
//   OPB_select             transfer valid
//   OPB_seqAddr            unused
//   Sl_DBus, Sl_xferAck    read data (zero outside ACK) and acknowledge
//   Sl_errAck/retry/toutSup tied low
//   user_data_out          register k at bits [32k+31:32k]
//   user_wr_stb            one-cycle pulse per written register
//   user_status_in         readback source for read-only registers
//   user_commit            (REG_BANK_SHADOW_EN only) shadow -> output copy
// -----------------------------------------------------------------------------
module opb_register_bank #(
   parameter logic [31:0]           C_BASEADDR   = 32'h010B2300,
   parameter logic [31:0]           C_HIGHADDR   = 32'h010B23FF,
   parameter int                    C_NUM_REGS   = 4,
   parameter logic [31:0]           C_RESET_VAL  = 32'h00000000,
   parameter logic [31:0]           C_PULSE_MASK = 32'h00000000,
   parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic [0:31]             OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:31]             OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:31]             Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   output logic [32*C_NUM_REGS-1:0] user_data_out,
   output logic [C_NUM_REGS-1:0]   user_wr_stb,
   input  logic [32*C_NUM_REGS-1:0] user_status_in
`ifdef REG_BANK_SHADOW_EN
   ,
   input  logic                    user_commit
`endif
);

   typedef enum logic {IDLE, ACK} state_t;

   state_t                  state_q, state_d;
   logic [31:0]             addr;
   logic [31:0]             off;
   logic                    hit;
   logic [C_NUM_REGS-1:0]   sel_d, sel_q;
   logic                    rnw_q;
   logic [0:3]              be_q;
   logic [0:31]             dbus_q;
   logic [31:0]             be_mask;
   logic [31:0]             wr_data;
   logic [C_NUM_REGS-1:0]   wr_en;
   logic [31:0]             bank_q   [C_NUM_REGS];
   logic [31:0]             bank_nxt [C_NUM_REGS];
   logic [31:0]             rd_data;
   logic                    unused_ok;

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // OPB bit 0 is the MSB, so a plain assignment keeps the numeric value.
   assign addr = OPB_ABus;
   assign off  = addr - C_BASEADDR;
   assign hit  = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

   assign unused_ok = ^{OPB_seqAddr, off[1:0]};

   // One-hot register select; an in-window index beyond C_NUM_REGS decodes to
   // all zeros, which makes reads return 0 and writes fall on the floor.
   always_comb begin
      sel_d = '0;
      for (int k = 0; k < C_NUM_REGS; k++)
         sel_d[k] = (off[31:2] == 30'(k));
   end

   // ---- Stage: FSM state register
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // ---- Stage: FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hit) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- Stage: FSM outputs (data bus is OR-ed with other slaves, so zero
   // whenever this slave is not acknowledging a read)
   always_comb begin
      Sl_xferAck = (state_q == ACK);
      Sl_DBus    = '0;
      if (state_q == ACK && rnw_q)
         Sl_DBus = rd_data;
   end

   // ---- Stage: request capture (control)
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         sel_q <= '0;
         rnw_q <= 1'b1;
      end else if (state_q == IDLE && hit) begin
         sel_q <= sel_d;
         rnw_q <= OPB_RNW;
      end
   end

   // ---- Stage: request capture (data)
   always_ff @(posedge OPB_Clk) begin
      if (state_q == IDLE && hit) begin
         be_q   <= OPB_BE;
         dbus_q <= OPB_DBus;
      end
   end

   // BE[0] selects the most significant byte.
   assign be_mask = {{8{be_q[0]}}, {8{be_q[1]}}, {8{be_q[2]}}, {8{be_q[3]}}};
   assign wr_data = dbus_q;

   always_comb begin
      for (int k = 0; k < C_NUM_REGS; k++)
         wr_en[k] = (state_q == ACK) && !rnw_q && sel_q[k] && !C_RO_MASK[k];
   end

   // Pulse bits clear in the cycle the strobe is high, i.e. one cycle after
   // the write; a write landing on that same edge overrides the clear.
   always_comb begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
         bank_nxt[k] = user_wr_stb[k] ? (bank_q[k] & ~C_PULSE_MASK) : bank_q[k];
         if (wr_en[k])
            bank_nxt[k] = (bank_nxt[k] & ~be_mask) | (wr_data & be_mask);
      end
   end

   // ---- Stage: register bank (shadow set when REG_BANK_SHADOW_EN)
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         for (int k = 0; k < C_NUM_REGS; k++)
            bank_q[k] <= C_RESET_VAL;
         user_wr_stb <= '0;
      end else begin
         for (int k = 0; k < C_NUM_REGS; k++)
            bank_q[k] <= bank_nxt[k];
         user_wr_stb <= wr_en;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < C_NUM_REGS; k++)
         if (sel_q[k])
            rd_data = rd_data | (C_RO_MASK[k] ? user_status_in[32*k +: 32] : bank_q[k]);
   end

`ifdef REG_BANK_SHADOW_EN
   logic [31:0] out_q [C_NUM_REGS];
   logic        commit_d_q;

   // ---- Stage: committed output set. Commit takes bank_nxt so a write on
   // the same edge is the value that gets committed.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         for (int k = 0; k < C_NUM_REGS; k++)
            out_q[k] <= C_RESET_VAL;
         commit_d_q <= 1'b0;
      end else begin
         for (int k = 0; k < C_NUM_REGS; k++) begin
            if (user_commit)
               out_q[k] <= bank_nxt[k];
            else if (commit_d_q)
               out_q[k] <= out_q[k] & ~C_PULSE_MASK;
         end
         commit_d_q <= user_commit;
      end
   end

   always_comb begin
      user_data_out = '0;
      for (int k = 0; k < C_NUM_REGS; k++)
         user_data_out[32*k +: 32] = out_q[k];
   end
`else
   always_comb begin
      user_data_out = '0;
      for (int k = 0; k < C_NUM_REGS; k++)
         user_data_out[32*k +: 32] = bank_q[k];
   end
`endif

endmodule

// File: tb/tb_opb_register_bank.sv
module tb_opb_register_bank;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [0:31]   abus;
   logic [0:3]    be;
   logic [0:31]   dbus_in;
   logic          rnw;
   logic          sel;
   logic          seq;
   logic [0:31]   sl_dbus;
   logic          ack;
   logic          err_ack;
   logic          retry;
   logic          tout_sup;
   logic [127:0]  udo;
   logic [3:0]    stb;
   logic [127:0]  status;
   logic          commit;
   logic [127:0]  udo_at_ack;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        ack;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   opb_register_bank #(
      .C_BASEADDR   (32'h010B2300),
      .C_HIGHADDR   (32'h010B23FF),
      .C_NUM_REGS   (4),
      .C_RESET_VAL  (32'hA5A5A5A5),
      .C_PULSE_MASK (32'h00000001),
      .C_RO_MASK    (4'b0100)
   ) dut (
      .OPB_Clk        (clk),
      .OPB_Rst_n      (rst_n),
      .OPB_ABus       (abus),
      .OPB_BE         (be),
      .OPB_DBus       (dbus_in),
      .OPB_RNW        (rnw),
      .OPB_select     (sel),
      .OPB_seqAddr    (seq),
      .Sl_DBus        (sl_dbus),
      .Sl_xferAck     (ack),
      .Sl_errAck      (err_ack),
      .Sl_retry       (retry),
      .Sl_toutSup     (tout_sup),
      .user_data_out  (udo),
      .user_wr_stb    (stb),
      .user_status_in (status)
`ifdef REG_BANK_SHADOW_EN
      ,
      .user_commit    (commit)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; returns in the cycle after the ACK
   // cycle, where written data and strobes are visible.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic r,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic exp_ack, input logic [31:0] exp_rd);
      exp_t e;
      sb.push_back('{ack: exp_ack, rd: exp_rd});
      abus = addr; rnw = r; be = b; dbus_in = d; sel = 1'b1;
      #1 chk({tag, "_noack_early"}, 32'(ack), 32'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      udo_at_ack = udo;
      chk({tag, "_ack"}, 32'(ack), 32'(e.ack));
      if (e.ack && r) chk({tag, "_rdata"}, sl_dbus, e.rd);
      if (!e.ack) begin
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk({tag, "_noack"}, 32'(ack), 32'd0);
         end
      end
      sel = 1'b0; rnw = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ack_off"}, 32'(ack), 32'd0);
      if (r) chk({tag, "_dbus_idle"}, sl_dbus, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; rnw = 1'b1; abus = '0; be = '0; dbus_in = '0;
      seq = 1'b0; commit = 1'b1; udo_at_ack = '0;
      status = {32'h0BADBEEF, 32'hCAFEF00D, 32'h00000000, 32'h00000000};

      // Reset state
      repeat (3) @(posedge clk); #1;
      chk("rst_ack",  32'(ack), 32'd0);
      chk("rst_dbus", sl_dbus, 32'd0);
      chk("rst_stb",  32'(stb), 32'd0);
      chk("rst_r0",   udo[31:0],   32'hA5A5A5A5);
      chk("rst_r1",   udo[63:32],  32'hA5A5A5A5);
      chk("rst_r3",   udo[127:96], 32'hA5A5A5A5);
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("post_rst_r1", udo[63:32], 32'hA5A5A5A5);
      chk("post_rst_ack", 32'(ack), 32'd0);

      // Full write and readback
      xfer("wr_full", 32'h010B2304, 1'b0, 4'b1111, 32'h12345678, 1'b1, 32'h0);
      chk("wr_full_old_at_ack", udo_at_ack[63:32], 32'hA5A5A5A5);
      chk("wr_full_data", udo[63:32], 32'h12345678);
      chk("wr_full_stb",  32'(stb), 32'h2);
      @(posedge clk); #1;
      chk("wr_full_stb_once", 32'(stb), 32'h0);
      xfer("rd_full", 32'h010B2304, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h12345678);

      // Partial (byte 1) write; read with low address bits set
      xfer("wr_part", 32'h010B2304, 1'b0, 4'b0100, 32'hDEADBEEF, 1'b1, 32'h0);
      chk("wr_part_data", udo[63:32], 32'h12AD5678);
      xfer("rd_part", 32'h010B2307, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h12AD5678);

      // Pulse bit: written 1, high for one cycle, back-to-back re-pulse
      xfer("pulse1", 32'h010B2300, 1'b0, 4'b1111, 32'h00000001, 1'b1, 32'h0);
      chk("pulse1_high", udo[31:0], 32'h00000001);
      chk("pulse1_stb",  32'(stb), 32'h1);
      xfer("pulse2", 32'h010B2300, 1'b0, 4'b1111, 32'h00000001, 1'b1, 32'h0);
      chk("pulse1_cleared", udo_at_ack[31:0], 32'h00000000);
      chk("pulse2_high", udo[31:0], 32'h00000001);
      @(posedge clk); #1;
      chk("pulse2_cleared", udo[31:0], 32'h00000000);

      // Read-only register
      xfer("rd_ro", 32'h010B2308, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D);
      xfer("wr_ro", 32'h010B2308, 1'b0, 4'b1111, 32'h12345678, 1'b1, 32'h0);
      chk("wr_ro_stb", 32'(stb), 32'h0);
      status[95:64] = 32'h13579BDF;
      xfer("rd_ro_live", 32'h010B2308, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h13579BDF);

      // Unmapped index inside the window
      xfer("rd_unmap", 32'h010B2328, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0);
      xfer("wr_unmap", 32'h010B2328, 1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0);
      chk("wr_unmap_stb", 32'(stb), 32'h0);
      chk("wr_unmap_r0", udo[31:0],   32'h00000000);
      chk("wr_unmap_r1", udo[63:32],  32'h12AD5678);
      chk("wr_unmap_r3", udo[127:96], 32'hA5A5A5A5);

      // Outside the window
      xfer("rd_out_hi", 32'h010B2400, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0);
      xfer("wr_out_lo", 32'h010B22FC, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0);
      chk("wr_out_stb", 32'(stb), 32'h0);
      chk("wr_out_r1",  udo[63:32], 32'h12AD5678);

      // Least significant byte only
      xfer("wr_lsb", 32'h010B230C, 1'b0, 4'b0001, 32'h000000FF, 1'b1, 32'h0);
      chk("wr_lsb_data", udo[127:96], 32'hA5A5A5FF);
      chk("wr_lsb_stb",  32'(stb), 32'h8);

`ifdef REG_BANK_SHADOW_EN
      commit = 1'b0;
      xfer("wr_shadow", 32'h010B2304, 1'b0, 4'b1111, 32'h11111111, 1'b1, 32'h0);
      chk("shadow_hold", udo[63:32], 32'h12AD5678);
      chk("shadow_stb",  32'(stb), 32'h2);
      xfer("rd_shadow", 32'h010B2304, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h11111111);
      chk("shadow_hold2", udo[63:32], 32'h12AD5678);
      commit = 1'b1;
      @(posedge clk); #1;
      chk("shadow_commit", udo[63:32], 32'h11111111);
`endif

      // Asynchronous reset in the ACK cycle
      abus = 32'h010B230C; rnw = 1'b0; be = 4'b1111; dbus_in = 32'h00000000; sel = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_ack_before", 32'(ack), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_ack", 32'(ack), 32'd0);
      chk("rst_mid_r3",  udo[127:96], 32'hA5A5A5A5);
      chk("rst_mid_r1",  udo[63:32],  32'hA5A5A5A5);
      sel = 1'b0; rnw = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_noack", 32'(ack), 32'd0);
      chk("rst_mid_stb",   32'(stb), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_rel_noack", 32'(ack), 32'd0);
         chk("rst_rel_r3",    udo[127:96], 32'hA5A5A5A5);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
